seq_hex_player: RTL and testbench

- Parametrised successor to the fixed-pattern stepping counter with prescaler and 7-segment decode.
- Steps through a programmable table of 4-bit values at a prescaled rate and drives one active-low 7-segment digit.
- Adds the following over the fixed-pattern block:
  - run-time table writes
  - forward/backward direction
  - loop or one-shot mode
  - single-step when paused
  - restart
  - wrap/done status
- Sits between board clock/buttons and a single HEX display.

---
 rtl/seq_hex_player_if.sv | 33 +++
 rtl/seq_hex_player.sv | 146 ++++++++++++++
 tb/tb_seq_hex_player.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_hex_player_if.sv
// Control, table-write and display signals of seq_hex_player, grouped as one bundle.
// The controller (board logic or bench) uses the master modport; the player uses slave.
interface seq_hex_player_if #(
    parameter int ADDR_W = 4
);
    // Controls are level inputs except step/restart/wr_en, which are one-cycle strobes
    // sampled on the rising clock edge; no back-pressure exists on this bundle.
    logic              run;
    logic              dir;
    logic              loop;
    logic              step;
    logic              restart;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;

    logic [ADDR_W-1:0] idx;
    logic [3:0]        value;
    logic [6:0]        seg;
    logic              tick;
    logic              wrap;
    logic              done;

    modport master (
        output run, dir, loop, step, restart, wr_en, wr_addr, wr_data,
        input  idx, value, seg, tick, wrap, done
    );

    modport slave (
        input  run, dir, loop, step, restart, wr_en, wr_addr, wr_data,
        output idx, value, seg, tick, wrap, done
    );
endinterface

// File: rtl/seq_hex_player.sv
// Programmable-table sequence player: steps a table of hex digits at a prescaled rate
// (or by single steps while paused) and drives one active-low 7-segment digit.
module seq_hex_player #(
    parameter int DIV_COUNT = 6250000,
    parameter int SEQ_LEN   = 8,
    parameter int ADDR_W    = 4
) (
    input logic             clk,
    input logic             rst,
    seq_hex_player_if.slave bus
);
    localparam int TBL = 1 << ADDR_W;
    localparam int PW  = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

    localparam logic [PW-1:0]     PRE_LAST = PW'(DIV_COUNT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SEQ_LEN - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_W    = (ADDR_W + 1)'(SEQ_LEN);
    localparam logic [PW-1:0]     PRE_ONE  = PW'(1);

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     presc_q;
    logic [ADDR_W-1:0] idx_q;
    logic              tick_q;
    logic              wrap_q;
    logic [3:0]        table_q [TBL];

    logic              active;
    logic              tick_hit;
    logic              advance;
    logic              at_end;
    logic [ADDR_W-1:0] idx_step;
    logic [ADDR_W-1:0] idx_wrap;
    logic              wr_ok;

    function automatic logic [3:0] init_val(input int i);
        case (i)
            0:       init_val = 4'h0;
            1:       init_val = 4'hB;
            2:       init_val = 4'h9;
            3:       init_val = 4'h6;
            4:       init_val = 4'h1;
            5:       init_val = 4'h8;
            6:       init_val = 4'h2;
            7:       init_val = 4'h7;
            default: init_val = 4'h0;
        endcase
    endfunction

    // Active-low {g,f,e,d,c,b,a} glyphs.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        active   = bus.run && (state_q == ST_PLAY);
        tick_hit = active && (presc_q == PRE_LAST);
        advance  = tick_hit || (!bus.run && bus.step && (state_q == ST_PLAY));
        at_end   = bus.dir ? (idx_q == '0) : (idx_q == IDX_LAST);
        idx_step = bus.dir ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
        idx_wrap = bus.dir ? IDX_LAST : '0;
        wr_ok    = bus.wr_en && ({1'b0, bus.wr_addr} < LEN_W);
    end

    // Restart outranks any advance on the same edge and never produces a wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_PLAY;
            presc_q <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (bus.restart) begin
            state_q <= ST_PLAY;
            presc_q <= '0;
            idx_q   <= idx_wrap;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q <= tick_hit;
            wrap_q <= 1'b0;
            if (active) begin
                presc_q <= tick_hit ? '0 : (presc_q + PRE_ONE);
            end
            case (state_q)
                ST_PLAY: begin
                    if (advance) begin
                        if (!at_end) begin
                            idx_q <= idx_step;
                        end else if (bus.loop) begin
                            idx_q  <= idx_wrap;
                            wrap_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_DONE;
            endcase
        end
    end

    // Entries at or beyond SEQ_LEN are never written and stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL; i++) begin
                table_q[i] <= init_val(i);
            end
        end else if (wr_ok) begin
            for (int i = 0; i < TBL; i++) begin
                if (bus.wr_addr == ADDR_W'(i)) begin
                    table_q[i] <= bus.wr_data;
                end
            end
        end
    end

    assign bus.idx   = idx_q;
    assign bus.value = table_q[idx_q];
    assign bus.seg   = hex7(table_q[idx_q]);
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_seq_hex_player.sv
// Directed bench for seq_hex_player: one DIV_COUNT=4 instance for sequencing, table and
// reset scenarios, one DIV_COUNT=1 instance for every-cycle stepping and pause/resume.
module tb_seq_hex_player;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_hex_player_if #(.ADDR_W(4)) b4 ();
    seq_hex_player_if #(.ADDR_W(4)) b1 ();

    seq_hex_player #(.DIV_COUNT(4), .SEQ_LEN(8), .ADDR_W(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    seq_hex_player #(.DIV_COUNT(1), .SEQ_LEN(8), .ADDR_W(4)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    logic [3:0] tab0  [8]  = '{4'h0, 4'hB, 4'h9, 4'h6, 4'h1, 4'h8, 4'h2, 4'h7};
    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        b4.restart = 1'b1;
        cyc(1);
        b4.restart = 1'b0;
    endtask

    task automatic pulse_step();
        b4.step = 1'b1;
        cyc(1);
        b4.step = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if (b4.idx !== 4'd0 || b4.value !== 4'h0 || b4.seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_out idx=%0d value=%h seg=%b exp 0 0 1000000", b4.idx, b4.value, b4.seg);
        end
        n_tests++;
        if (b4.tick !== 1'b0 || b4.wrap !== 1'b0 || b4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags tick=%b wrap=%b done=%b exp 000", b4.tick, b4.wrap, b4.done);
        end
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_forward_loop();
        logic [3:0] e_idx;
        b4.run = 1'b1; b4.dir = 1'b0; b4.loop = 1'b1;
        pulse_restart();
        for (int k = 1; k <= 8; k++) begin
            cyc(3);
            e_idx = 4'((k - 1) % 8);
            n_tests++;
            if (b4.tick !== 1'b0 || b4.idx !== e_idx) begin
                n_fail++;
                $display("FAIL fwd_pre k=%0d tick=%b idx=%0d exp 0 %0d", k, b4.tick, b4.idx, e_idx);
            end
            cyc(1);
            e_idx = 4'(k % 8);
            n_tests++;
            if (b4.idx !== e_idx || b4.value !== tab0[e_idx[2:0]] || b4.seg !== glyph[tab0[e_idx[2:0]]]
                || b4.tick !== 1'b1 || b4.wrap !== (k == 8)) begin
                n_fail++;
                $display("FAIL fwd_tick k=%0d idx=%0d value=%h seg=%b tick=%b wrap=%b exp idx %0d value %h",
                         k, b4.idx, b4.value, b4.seg, b4.tick, b4.wrap, e_idx, tab0[e_idx[2:0]]);
            end
        end
    endtask

    task automatic test_oneshot();
        b4.loop = 1'b0;
        pulse_restart();
        cyc(28);
        n_tests++;
        if (b4.idx !== 4'd7 || b4.value !== 4'h7 || b4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_last idx=%0d value=%h done=%b exp 7 7 0", b4.idx, b4.value, b4.done);
        end
        cyc(4);
        n_tests++;
        if (b4.idx !== 4'd7 || b4.done !== 1'b1 || b4.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_done idx=%0d done=%b wrap=%b exp 7 1 0", b4.idx, b4.done, b4.wrap);
        end
        for (int c = 0; c < 9; c++) begin
            cyc(1);
            n_tests++;
            if (b4.tick !== 1'b0 || b4.idx !== 4'd7 || b4.done !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_hold c=%0d tick=%b idx=%0d done=%b exp 0 7 1", c, b4.tick, b4.idx, b4.done);
            end
        end
        pulse_restart();
        n_tests++;
        if (b4.idx !== 4'd0 || b4.done !== 1'b0 || b4.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_restart idx=%0d done=%b wrap=%b exp 0 0 0", b4.idx, b4.done, b4.wrap);
        end
        cyc(4);
        n_tests++;
        if (b4.idx !== 4'd1 || b4.value !== 4'hB || b4.tick !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_resume idx=%0d value=%h tick=%b exp 1 b 1", b4.idx, b4.value, b4.tick);
        end
    endtask

    task automatic test_backward_step();
        logic [3:0] e_idx;
        b4.dir = 1'b1; b4.loop = 1'b1;
        pulse_restart();
        n_tests++;
        if (b4.idx !== 4'd7 || b4.value !== 4'h7) begin
            n_fail++;
            $display("FAIL bwd_restart idx=%0d value=%h exp 7 7", b4.idx, b4.value);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(4);
            e_idx = 4'((15 - k) % 8);
            n_tests++;
            if (b4.idx !== e_idx || b4.wrap !== (k == 8)) begin
                n_fail++;
                $display("FAIL bwd_tick k=%0d idx=%0d wrap=%b exp %0d %b", k, b4.idx, b4.wrap, e_idx, k == 8);
            end
        end
        b4.run = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            pulse_step();
            n_tests++;
            if (b4.idx !== 4'(7 - s)) begin
                n_fail++;
                $display("FAIL step_paused s=%0d idx=%0d exp %0d", s, b4.idx, 7 - s);
            end
        end
        cyc(6);
        n_tests++;
        if (b4.idx !== 4'd5 || b4.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL paused_hold idx=%0d tick=%b exp 5 0", b4.idx, b4.tick);
        end
        b4.run = 1'b1;
        pulse_step();
        b4.run = 1'b0;
        cyc(1);
        n_tests++;
        if (b4.idx !== 4'd5) begin
            n_fail++;
            $display("FAIL step_running idx=%0d exp 5", b4.idx);
        end
    endtask

    task automatic test_table_write();
        b4.dir = 1'b0;
        pulse_restart();
        pulse_step(); pulse_step(); pulse_step();
        n_tests++;
        if (b4.idx !== 4'd3 || b4.value !== 4'h6) begin
            n_fail++;
            $display("FAIL wr_pre idx=%0d value=%h exp 3 6", b4.idx, b4.value);
        end
        b4.wr_en = 1'b1; b4.wr_addr = 4'd3; b4.wr_data = 4'hF;
        cyc(1);
        b4.wr_en = 1'b0;
        n_tests++;
        if (b4.value !== 4'hF || b4.seg !== 7'b0001110) begin
            n_fail++;
            $display("FAIL wr_current value=%h seg=%b exp f 0001110", b4.value, b4.seg);
        end
        b4.wr_en = 1'b1; b4.wr_addr = 4'd12; b4.wr_data = 4'h5;
        cyc(1);
        b4.wr_en = 1'b0;
        pulse_step();
        n_tests++;
        if (b4.idx !== 4'd4 || b4.value !== 4'h1) begin
            n_fail++;
            $display("FAIL wr_out_of_range idx=%0d value=%h exp 4 1", b4.idx, b4.value);
        end
        b4.wr_en = 1'b1; b4.wr_addr = 4'd5; b4.wr_data = 4'hC;
        pulse_step();
        b4.wr_en = 1'b0;
        n_tests++;
        if (b4.idx !== 4'd5 || b4.value !== 4'hC || b4.seg !== 7'b1000110) begin
            n_fail++;
            $display("FAIL wr_with_step idx=%0d value=%h seg=%b exp 5 c 1000110", b4.idx, b4.value, b4.seg);
        end
    endtask

    task automatic test_step_restart();
        b4.step = 1'b1; b4.restart = 1'b1;
        cyc(1);
        b4.step = 1'b0; b4.restart = 1'b0;
        n_tests++;
        if (b4.idx !== 4'd0 || b4.wrap !== 1'b0 || b4.done !== 1'b0 || b4.value !== 4'h0) begin
            n_fail++;
            $display("FAIL step_restart idx=%0d wrap=%b done=%b value=%h exp 0 0 0 0",
                     b4.idx, b4.wrap, b4.done, b4.value);
        end
    endtask

    task automatic test_reset_mid();
        b4.wr_en = 1'b1; b4.wr_addr = 4'd0; b4.wr_data = 4'hE;
        cyc(1);
        b4.wr_en = 1'b0;
        n_tests++;
        if (b4.value !== 4'hE || b4.seg !== 7'b0000110) begin
            n_fail++;
            $display("FAIL entry0_write value=%h seg=%b exp e 0000110", b4.value, b4.seg);
        end
        b4.run = 1'b1; b4.loop = 1'b1;
        cyc(20);
        n_tests++;
        if (b4.idx !== 4'd5 || b4.value !== 4'hC) begin
            n_fail++;
            $display("FAIL mid_run idx=%0d value=%h exp 5 c", b4.idx, b4.value);
        end
        rst = 1'b1;
        #2;
        n_tests++;
        if (b4.idx !== 4'd0 || b4.value !== 4'h0 || b4.seg !== 7'b1000000
            || b4.tick !== 1'b0 || b4.wrap !== 1'b0 || b4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset idx=%0d value=%h seg=%b tick=%b wrap=%b done=%b exp 0 0 1000000 0 0 0",
                     b4.idx, b4.value, b4.seg, b4.tick, b4.wrap, b4.done);
        end
        b4.run = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic test_div1();
        b1.run = 1'b1; b1.dir = 1'b0; b1.loop = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            n_tests++;
            if (b1.idx !== 4'(k) || b1.tick !== 1'b1) begin
                n_fail++;
                $display("FAIL div1_run k=%0d idx=%0d tick=%b exp %0d 1", k, b1.idx, b1.tick, k);
            end
        end
        b1.run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            n_tests++;
            if (b1.idx !== 4'd3 || b1.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL div1_pause c=%0d idx=%0d tick=%b exp 3 0", c, b1.idx, b1.tick);
            end
        end
        b1.run = 1'b1;
        for (int k = 4; k <= 5; k++) begin
            cyc(1);
            n_tests++;
            if (b1.idx !== 4'(k) || b1.value !== tab0[k]) begin
                n_fail++;
                $display("FAIL div1_resume k=%0d idx=%0d value=%h exp %0d %h", k, b1.idx, b1.value, k, tab0[k]);
            end
        end
        b1.run = 1'b0;
    endtask

    initial begin
        b4.run = 1'b0; b4.dir = 1'b0; b4.loop = 1'b0; b4.step = 1'b0; b4.restart = 1'b0;
        b4.wr_en = 1'b0; b4.wr_addr = '0; b4.wr_data = '0;
        b1.run = 1'b0; b1.dir = 1'b0; b1.loop = 1'b0; b1.step = 1'b0; b1.restart = 1'b0;
        b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0;
        test_reset();
        test_forward_loop();
        test_oneshot();
        test_backward_step();
        test_table_write();
        test_step_restart();
        test_reset_mid();
        test_div1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
